march_bist_ctrl: RTL and testbench

//  March C- BIST sequencer for the 256x4b SRAM. After start, owns the SRAM port and

---
 rtl/march_bist_ctrl_if.sv | 31 +++
 rtl/march_bist_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_march_bist_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/march_bist_ctrl_if.sv
// SRAM access bundle between the March C- BIST sequencer and the 256x4b SRAM macro.
// Latency: sram_dout is valid one cycle after a read is issued (sram_en=1, sram_we=0).
// Backpressure: none; the SRAM accepts one access every cycle.
interface march_bist_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic              sram_we;
  logic              sram_en;
  logic [DATA_W-1:0] sram_dout;

  // BIST sequencer side: drives the access, receives read data
  modport master (
    output sram_addr,
    output sram_din,
    output sram_we,
    output sram_en,
    input  sram_dout
  );

  // SRAM macro side
  modport slave (
    input  sram_addr,
    input  sram_din,
    input  sram_we,
    input  sram_en,
    output sram_dout
  );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: sweeps M0..M5 over the SRAM, sticky go_nogo on any miscompare.
// Latency: first access 1 cycle after start, 10N accesses back to back, done 10N+2 cycles after start.
// Backpressure: none; start is ignored while a run is in progress (RUN/TAIL).
// Optional macro BIST_FAIL_CAPTURE_EN: latch the address of the first miscompare on fail_addr.
module march_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  march_bist_ctrl_if.master sram,
  output logic              busy,
  output logic              done,
  output logic              go_nogo,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL, S_DONE} state_e;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;

  state_e            state_q, state_d;
  elem_e             elem_q, elem_d, elem_nx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;   // 0 = read half, 1 = write half of a two-op element
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              go_nogo_q, go_nogo_d;
  logic [DATA_W-1:0] exp_q, exp_d;       // expected word for the read issued last cycle
  logic              exp_vld_q, exp_vld_d;

  logic start_acc;
  logic miscmp;
  logic down;
  logic last_addr;

  // Write background of an element: M1 and M3 write ones, M0/M2/M4 write zeros
  function automatic logic [DATA_W-1:0] elem_wdata(input elem_e e);
    return {DATA_W{(e == M1) || (e == M3)}};
  endfunction

  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign miscmp    = exp_vld_q && (sram.sram_dout != exp_q);
  assign down      = (elem_q == M3) || (elem_q == M4) || (elem_q == M5);
  assign last_addr = down ? (addr_q == '0) : (addr_q == '1);
  assign elem_nx   = elem_e'(elem_q + 3'd1);

  // Next-state: element/address sequencing, registered SRAM controls, compare and status
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    en_d      = en_q;
    we_d      = we_q;
    din_d     = din_q;
    busy_d    = busy_q;
    done_d    = done_q;
    go_nogo_d = go_nogo_q | miscmp;
    exp_vld_d = en_q & ~we_q;
    exp_d     = {DATA_W{(elem_q == M2) || (elem_q == M4)}};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_d   = S_RUN;
          elem_d    = M0;
          addr_d    = '0;
          phase_d   = 1'b0;
          en_d      = 1'b1;
          we_d      = 1'b1;
          din_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          go_nogo_d = 1'b0;
        end
      end
      S_RUN: begin
        if ((elem_q != M0) && (elem_q != M5) && !phase_q) begin
          // read half done: write the same address next cycle
          phase_d = 1'b1;
          we_d    = 1'b1;
          din_d   = elem_wdata(elem_q);
        end else begin
          phase_d = 1'b0;
          if (!last_addr) begin
            addr_d = down ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
            we_d   = (elem_q == M0);
            if (elem_q == M0) din_d = elem_wdata(elem_q);
          end else if (elem_q == M5) begin
            state_d = S_TAIL;
            en_d    = 1'b0;
            we_d    = 1'b0;
          end else begin
            // M1..M5 all open with a read; M3..M5 sweep downward from the top
            elem_d = elem_nx;
            addr_d = ((elem_nx == M3) || (elem_nx == M4) || (elem_nx == M5)) ? '1 : '0;
            we_d   = 1'b0;
          end
        end
      end
      S_TAIL: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and all registered outputs; synchronous reset aborts any run
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      elem_q    <= M0;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      din_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      go_nogo_q <= 1'b0;
      exp_q     <= '0;
      exp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      addr_q    <= addr_d;
      phase_q   <= phase_d;
      en_q      <= en_d;
      we_q      <= we_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      go_nogo_q <= go_nogo_d;
      exp_q     <= exp_d;
      exp_vld_q <= exp_vld_d;
    end
  end

`ifdef BIST_FAIL_CAPTURE_EN
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;   // address of the read being compared

  // Latch only the first miscompare of a run; cleared when a new run starts
  always_comb begin
    exp_addr_d  = addr_q;
    fail_addr_d = fail_addr_q;
    if (start_acc) begin
      fail_addr_d = '0;
    end else if (miscmp && !go_nogo_q) begin
      fail_addr_d = exp_addr_q;
    end
  end

  // Capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_addr_q <= '0;
      exp_addr_q  <= '0;
    end else begin
      fail_addr_q <= fail_addr_d;
      exp_addr_q  <= exp_addr_d;
    end
  end

  assign fail_addr = fail_addr_q;
`else
  assign fail_addr = '0;
`endif

  assign sram.sram_addr = addr_q;
  assign sram.sram_din  = din_q;
  assign sram.sram_we   = we_q;
  assign sram.sram_en   = en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign go_nogo        = go_nogo_q;

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl with a behavioural 256x4 SRAM and injectable faults.
// Timing: outputs sampled on negedge; cycle k=1 is the first cycle after the start edge.
// Fault modes: 0 none, 1 bit 2 of 0x3A stuck at 1, 2 write to 0x10 flips bit 0 of 0x11.
module tb_march_bist_ctrl;
  localparam int N    = 256;
  localparam int MAXK = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       go_nogo;
  logic [7:0] fail_addr;

  march_bist_ctrl_if #(.ADDR_W(8), .DATA_W(4)) bus ();

  march_bist_ctrl #(.ADDR_W(8), .DATA_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sram      (bus),
    .busy      (busy),
    .done      (done),
    .go_nogo   (go_nogo),
    .fail_addr (fail_addr)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM with fault injection
  logic [3:0] mem [0:N-1];
  logic [3:0] model_dout = 4'h0;
  int         fault_mode = 0;
  assign bus.sram_dout = model_dout;

  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we) begin
        mem[bus.sram_addr] <= bus.sram_din;
        if (fault_mode == 2 && bus.sram_addr == 8'h10) mem[8'h11] <= mem[8'h11] ^ 4'b0001;
      end else begin
        if (fault_mode == 1 && bus.sram_addr == 8'h3A) model_dout <= mem[bus.sram_addr] | 4'b0100;
        else                                           model_dout <= mem[bus.sram_addr];
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] l_addr [0:MAXK];
  logic [3:0] l_din  [0:MAXK];
  logic       l_en   [0:MAXK];
  logic       l_we   [0:MAXK];
  logic       l_gng  [0:MAXK];
  logic       l_busy [0:MAXK];
  logic       l_done [0:MAXK];
  int         wr_cnt, rd_cnt, busy_cnt, done_k, seq_bad;
  logic [7:0] exp_fa_stuck, exp_fa_coup;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch a run and log outputs per cycle until done, an optional reset, or the cycle bound
  task automatic run(input int hold, input int repulse, input int rst_at);
    wr_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_k = 0;
    start = 1'b1;
    for (int k = 1; k <= MAXK; k++) begin
      @(negedge clk);
      l_addr[k] = bus.sram_addr;
      l_din[k]  = bus.sram_din;
      l_en[k]   = bus.sram_en;
      l_we[k]   = bus.sram_we;
      l_gng[k]  = go_nogo;
      l_busy[k] = busy;
      l_done[k] = done;
      if (bus.sram_en && bus.sram_we)  wr_cnt++;
      if (bus.sram_en && !bus.sram_we) rd_cnt++;
      if (busy) busy_cnt++;
      start = (k < hold) || (k == repulse);
      rst   = (k == rst_at);
      if (done) begin
        done_k = k;
        break;
      end
      if (k == rst_at + 1) break;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
`ifdef BIST_FAIL_CAPTURE_EN
    exp_fa_stuck = 8'h3A;
    exp_fa_coup  = 8'h11;
`else
    exp_fa_stuck = 8'h00;
    exp_fa_coup  = 8'h00;
`endif
    rst = 1'b1; start = 1'b0; fault_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_done",    32'(done), 0);
    chk("rst_gonogo",  32'(go_nogo), 0);
    chk("rst_failaddr",32'(fail_addr), 0);
    chk("rst_en",      32'(bus.sram_en), 0);
    chk("rst_we",      32'(bus.sram_we), 0);
    chk("rst_addr",    32'(bus.sram_addr), 0);
    chk("rst_din",     32'(bus.sram_din), 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: fault-free run
    fault_mode = 0;
    run(1, -1, -1);
    chk("t1_done_cycle", 32'(done_k), 2562);
    chk("t1_gonogo",     32'(go_nogo), 0);
    chk("t1_failaddr",   32'(fail_addr), 0);
    chk("t1_writes",     32'(wr_cnt), 1280);
    chk("t1_reads",      32'(rd_cnt), 1280);
    chk("t1_busy_cycles",32'(busy_cnt), 2561);
    chk("t1_first_en",   32'(l_en[1]), 1);
    chk("t1_first_we",   32'(l_we[1]), 1);
    chk("t1_first_addr", 32'(l_addr[1]), 0);
    chk("t1_last_we",    32'(l_we[2560]), 0);
    chk("t1_last_addr",  32'(l_addr[2560]), 0);
    chk("t1_tail_en",    32'(l_en[2561]), 0);
    chk("t1_tail_busy",  32'(l_busy[2561]), 1);

    // T6: full access order against a reference walk of the six elements
    seq_bad = 0;
    for (int k = 1; k <= 10 * N; k++) begin
      int j, e, o;
      logic [7:0] ea;
      logic       ew;
      logic [3:0] ed;
      j = k - 1;
      e = 0; o = 0;
      if (j < N) begin
        ea = j[7:0]; ew = 1'b1; ed = 4'h0;
      end else if (j < 9 * N) begin
        e  = (j - N) / (2 * N) + 1;
        o  = (j - N) % (2 * N);
        ew = (o % 2) == 1;
        ea = (e >= 3) ? 8'(N - 1 - o / 2) : 8'(o / 2);
        ed = (e == 1 || e == 3) ? 4'hF : 4'h0;
      end else begin
        ea = 8'(N - 1 - (j - 9 * N)); ew = 1'b0; ed = 4'h0;
      end
      if (l_en[k] !== 1'b1 || l_we[k] !== ew || l_addr[k] !== ea || (ew && l_din[k] !== ed))
        seq_bad++;
    end
    chk("t6_sequence_errors", 32'(seq_bad), 0);
    chk("t6_m0m1_en",   32'(l_en[257]), 1);
    chk("t6_m1_first",  32'({l_we[257], l_addr[257]}), 32'h000);
    chk("t6_m1_w1_din", 32'(l_din[258]), 32'hF);
    chk("t6_m2m3_en",   32'(l_en[1281]), 1);
    chk("t6_m3_first",  32'({l_we[1281], l_addr[1281]}), 32'h0FF);
    chk("t6_m3_second", 32'(l_addr[1283]), 32'hFE);
    chk("t6_m5_first",  32'({l_we[2305], l_addr[2305]}), 32'h0FF);

    // T2: stuck-at-1 on bit 2 of 0x3A, first seen by the M1 r0 at cycle 373
    fault_mode = 1;
    run(1, -1, -1);
    chk("t2_gonogo_before", 32'(l_gng[374]), 0);
    chk("t2_gonogo_set",    32'(l_gng[375]), 1);
    chk("t2_done_cycle",    32'(done_k), 2562);
    chk("t2_gonogo",        32'(go_nogo), 1);
    chk("t2_failaddr",      32'(fail_addr), 32'(exp_fa_stuck));

    // T3: coupling fault 0x10 -> 0x11 bit 0, first seen by the M1 r0 of 0x11 at cycle 291
    fault_mode = 2;
    run(1, -1, -1);
    chk("t3_gonogo_before", 32'(l_gng[292]), 0);
    chk("t3_gonogo_set",    32'(l_gng[293]), 1);
    chk("t3_done_cycle",    32'(done_k), 2562);
    chk("t3_gonogo",        32'(go_nogo), 1);
    chk("t3_failaddr",      32'(fail_addr), 32'(exp_fa_coup));

    // T5: relaunch from DONE after a failing run, start held 20 cycles, re-pulsed mid-run
    fault_mode = 0;
    run(20, 1000, -1);
    chk("t5_gonogo_cleared", 32'(l_gng[1]), 0);
    chk("t5_done_cleared",   32'(l_done[1]), 0);
    chk("t5_busy_first",     32'(l_busy[1]), 1);
    chk("t5_done_cycle",     32'(done_k), 2562);
    chk("t5_writes",         32'(wr_cnt), 1280);
    chk("t5_reads",          32'(rd_cnt), 1280);
    chk("t5_failaddr",       32'(fail_addr), 0);
    repeat (10) @(negedge clk);
    chk("t5_done_holds",     32'(done), 1);
    chk("t5_no_relaunch",    32'({busy, bus.sram_en}), 0);

    // T4: reset at cycle 700 of a failing run aborts it
    fault_mode = 1;
    run(1, -1, 700);
    chk("t4_gonogo_pre_rst", 32'(l_gng[700]), 1);
    chk("t4_busy",           32'(busy), 0);
    chk("t4_done",           32'(done), 0);
    chk("t4_gonogo",         32'(go_nogo), 0);
    chk("t4_failaddr",       32'(fail_addr), 0);
    chk("t4_sram_ctl",       32'({bus.sram_en, bus.sram_we}), 0);
    chk("t4_sram_addr_din",  32'({bus.sram_addr, bus.sram_din}), 0);
    repeat (3) @(negedge clk);
    chk("t4_stays_idle",     32'({busy, done, bus.sram_en}), 0);
    fault_mode = 0;
    run(1, -1, -1);
    chk("t4_rerun_done_cycle", 32'(done_k), 2562);
    chk("t4_rerun_gonogo",     32'(go_nogo), 0);
    chk("t4_rerun_writes",     32'(wr_cnt), 1280);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
